// File: rtl/acc_qcorr_multi_if.sv
// Stream interface of acc_qcorr_multi: qcorr sign beats in, packed window sums out.
// acc_sat_o is present only when ACC_QCORR_SAT_EN is defined.
interface acc_qcorr_multi_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int ACC_WIDTH    = 16,
  parameter int MAX_WINDOW   = 480,
  parameter int CNT_W        = $clog2(MAX_WINDOW + 1)
);
  logic                              clear_i;
  logic [CNT_W-1:0]                  win_len_i;
  logic                              qcorr_valid_i;
  logic [NUM_CHANNELS-1:0]           qcorr_data_i;
  logic                              qcorr_ready_o;
  logic                              acc_qcorr_valid_o;
  logic [NUM_CHANNELS*ACC_WIDTH-1:0] acc_qcorr_data_o;
  logic                              acc_qcorr_ready_i;
  logic                              acc_busy_o;
`ifdef ACC_QCORR_SAT_EN
  logic [NUM_CHANNELS-1:0]           acc_sat_o;
`endif

  modport slave (
    input  clear_i, win_len_i, qcorr_valid_i, qcorr_data_i, acc_qcorr_ready_i,
    output qcorr_ready_o, acc_qcorr_valid_o, acc_qcorr_data_o, acc_busy_o
`ifdef ACC_QCORR_SAT_EN
    , output acc_sat_o
`endif
  );

  modport master (
    output clear_i, win_len_i, qcorr_valid_i, qcorr_data_i, acc_qcorr_ready_i,
    input  qcorr_ready_o, acc_qcorr_valid_o, acc_qcorr_data_o, acc_busy_o
`ifdef ACC_QCORR_SAT_EN
    , input acc_sat_o
`endif
  );
endinterface

// File: rtl/acc_qcorr_multi.sv
// Multi-channel quantized-correlation accumulator: sums +1/-1 sign streams over a
// runtime window and emits one packed result per window. ACC_QCORR_SAT_EN selects saturation.
module acc_qcorr_multi #(
  parameter int NUM_CHANNELS = 4,
  parameter int ACC_WIDTH    = 16,
  parameter int MAX_WINDOW   = 480,
  parameter int CNT_W        = $clog2(MAX_WINDOW + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  acc_qcorr_multi_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

  localparam logic signed [ACC_WIDTH-1:0] STEP_UP = {{(ACC_WIDTH-1){1'b0}}, 1'b1};
  localparam logic signed [ACC_WIDTH-1:0] STEP_DN = '1;
`ifdef ACC_QCORR_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
`endif

  state_t                            state_q;
  logic [CNT_W-1:0]                  len_q;
  logic [CNT_W-1:0]                  cnt_q;
  logic [CNT_W-1:0]                  cnt_inc;
  logic                              rdy_q;
  logic                              beat;
  logic                              last_beat;
  logic signed [ACC_WIDTH-1:0]       acc_p0  [NUM_CHANNELS];
  logic signed [ACC_WIDTH-1:0]       acc_nxt [NUM_CHANNELS];
  logic [NUM_CHANNELS*ACC_WIDTH-1:0] res_p1;
  logic                              vld_p1;
`ifdef ACC_QCORR_SAT_EN
  logic [NUM_CHANNELS-1:0]           sat_p0;
  logic [NUM_CHANNELS-1:0]           sat_nxt;
  logic [NUM_CHANNELS-1:0]           sat_p1;
`endif

  function automatic logic [CNT_W-1:0] norm_len(input logic [CNT_W-1:0] l);
    if (l == '0)
      return CNT_W'(1);
    else if (l > CNT_W'(MAX_WINDOW))
      return CNT_W'(MAX_WINDOW);
    else
      return l;
  endfunction

`ifdef ACC_QCORR_SAT_EN
  function automatic logic clips(input logic signed [ACC_WIDTH-1:0] a, input logic up);
    return up ? (a == ACC_MAX) : (a == ACC_MIN);
  endfunction
`endif

  // The -1 step is an add of all-ones so both directions share one adder.
  function automatic logic signed [ACC_WIDTH-1:0] step_acc(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic                        up
  );
`ifdef ACC_QCORR_SAT_EN
    if (clips(a, up))
      return a;
`endif
    return a + (up ? STEP_UP : STEP_DN);
  endfunction

  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign beat      = bus.qcorr_valid_i & bus.qcorr_ready_o;
  assign last_beat = beat && (cnt_inc == len_q);

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      acc_nxt[c] = step_acc(acc_p0[c], bus.qcorr_data_i[c]);
    end
  end

`ifdef ACC_QCORR_SAT_EN
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      sat_nxt[c] = sat_p0[c] | clips(acc_p0[c], bus.qcorr_data_i[c]);
    end
  end
`endif

  // Stage p0: per-channel accumulation; stage p1: held result register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      vld_p1  <= 1'b0;
      res_p1  <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) acc_p0[c] <= '0;
`ifdef ACC_QCORR_SAT_EN
      sat_p0  <= '0;
      sat_p1  <= '0;
`endif
    end else if (bus.clear_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      vld_p1  <= 1'b0;
      for (int c = 0; c < NUM_CHANNELS; c++) acc_p0[c] <= '0;
`ifdef ACC_QCORR_SAT_EN
      sat_p0  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          len_q   <= norm_len(bus.win_len_i);
          cnt_q   <= '0;
          rdy_q   <= 1'b1;
          state_q <= ACCUM;
          for (int c = 0; c < NUM_CHANNELS; c++) acc_p0[c] <= '0;
`ifdef ACC_QCORR_SAT_EN
          sat_p0  <= '0;
          sat_p1  <= '0;
`endif
        end
        ACCUM: begin
          if (beat) begin
            cnt_q <= cnt_inc;
            for (int c = 0; c < NUM_CHANNELS; c++) acc_p0[c] <= acc_nxt[c];
`ifdef ACC_QCORR_SAT_EN
            sat_p0 <= sat_nxt;
`endif
            if (last_beat) begin
              for (int c = 0; c < NUM_CHANNELS; c++)
                res_p1[c*ACC_WIDTH +: ACC_WIDTH] <= acc_nxt[c];
`ifdef ACC_QCORR_SAT_EN
              sat_p1  <= sat_nxt;
`endif
              vld_p1  <= 1'b1;
              rdy_q   <= 1'b0;
              state_q <= OUTPUT;
            end
          end
        end
        OUTPUT: begin
          // Handshake doubles as the next window start, skipping IDLE.
          if (bus.acc_qcorr_ready_i) begin
            vld_p1  <= 1'b0;
            len_q   <= norm_len(bus.win_len_i);
            cnt_q   <= '0;
            rdy_q   <= 1'b1;
            state_q <= ACCUM;
            for (int c = 0; c < NUM_CHANNELS; c++) acc_p0[c] <= '0;
`ifdef ACC_QCORR_SAT_EN
            sat_p0  <= '0;
            sat_p1  <= '0;
`endif
          end
        end
        default: begin
          state_q <= IDLE;
          rdy_q   <= 1'b0;
          vld_p1  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.qcorr_ready_o     = rdy_q & ~bus.clear_i;
  assign bus.acc_qcorr_valid_o = vld_p1;
  assign bus.acc_qcorr_data_o  = res_p1;
  assign bus.acc_busy_o        = (state_q == ACCUM) && (cnt_q != '0);
`ifdef ACC_QCORR_SAT_EN
  assign bus.acc_sat_o         = sat_p1;
`endif

endmodule

// File: tb/tb_acc_qcorr_multi.sv
// Bench for acc_qcorr_multi: directed vector table, randomized windows against a
// sum-of-signs reference model, clear/reset corners and a narrow-accumulator overflow case.
module tb_acc_qcorr_multi;
  localparam int NC  = 4;
  localparam int AW  = 16;
  localparam int MW  = 480;
  localparam int CW  = $clog2(MW + 1);
  localparam int NAW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  acc_qcorr_multi_if #(.NUM_CHANNELS(NC), .ACC_WIDTH(AW),  .MAX_WINDOW(MW)) bus ();
  acc_qcorr_multi_if #(.NUM_CHANNELS(NC), .ACC_WIDTH(NAW), .MAX_WINDOW(MW)) nbus ();

  acc_qcorr_multi #(.NUM_CHANNELS(NC), .ACC_WIDTH(AW), .MAX_WINDOW(MW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus));
  acc_qcorr_multi #(.NUM_CHANNELS(NC), .ACC_WIDTH(NAW), .MAX_WINDOW(MW)) dut_n (
    .clk_i(clk), .rst_ni(rst_n), .bus(nbus));

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Reference model: per-channel signed sum of +1/-1 over the latched window length.
  int               m_sum [NC];
  int               m_cnt   = 0;
  int               m_len   = 1;
  bit               m_start = 1'b1;
  int               n_res   = 0;
  logic [NC*AW-1:0] exp_q [$];

  function automatic int norm(input int l);
    if (l == 0) return 1;
    if (l > MW) return MW;
    return l;
  endfunction

  function automatic int step_model(input int s, input logic up, input int w);
    int r;
    r = up ? s + 1 : s - 1;
`ifdef ACC_QCORR_SAT_EN
    if (r > (1 << (w - 1)) - 1) r = (1 << (w - 1)) - 1;
    if (r < -(1 << (w - 1)))    r = -(1 << (w - 1));
`else
    if (w < 0) r = 0;
`endif
    return r;
  endfunction

  function automatic logic [NC*AW-1:0] pack_sums();
    logic [NC*AW-1:0] v;
    for (int c = 0; c < NC; c++) v[c*AW +: AW] = AW'(m_sum[c]);
    return v;
  endfunction

  always @(negedge clk) begin
    if (!rst_n || bus.clear_i) begin
      for (int c = 0; c < NC; c++) m_sum[c] = 0;
      m_cnt   = 0;
      m_start = 1'b1;
      exp_q.delete();
    end else if (m_start) begin
      m_len   = norm(int'(bus.win_len_i));
      m_start = 1'b0;
    end else begin
      if (bus.qcorr_valid_i && bus.qcorr_ready_o) begin
        for (int c = 0; c < NC; c++) m_sum[c] = step_model(m_sum[c], bus.qcorr_data_i[c], AW);
        m_cnt++;
        if (m_cnt == m_len) begin
          exp_q.push_back(pack_sums());
          for (int c = 0; c < NC; c++) m_sum[c] = 0;
          m_cnt = 0;
        end
      end
      if (bus.acc_qcorr_valid_o && bus.acc_qcorr_ready_i) begin
        n_res++;
        if (exp_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL model_result: got %h, expected no result", bus.acc_qcorr_data_o);
        end else begin
          chk("model_result", bus.acc_qcorr_data_o, exp_q.pop_front());
        end
        m_len = norm(int'(bus.win_len_i));
      end
    end
  end

  typedef struct {
    logic [CW-1:0]          win;
    int                     nb;
    logic [15:0][NC-1:0]    pat;
    logic [NC-1:0][AW-1:0]  res;
  } vec_t;

  vec_t tbl [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [NC-1:0] d);
    bit took;
    took = 1'b0;
    bus.qcorr_valid_i = 1'b1;
    bus.qcorr_data_i  = d;
    for (int k = 0; k < 40 && !took; k++) begin
      @(negedge clk);
      took = bus.qcorr_ready_o;
      tick();
    end
    bus.qcorr_valid_i = 1'b0;
    if (!took) begin
      nvec++;
      nerr++;
      $display("FAIL beat_timeout: ready stayed 0 for 40 cycles, expected 1");
    end
  endtask

  task automatic pulse_clear();
    bus.clear_i = 1'b1;
    tick();
    bus.clear_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int ncnt;

    tbl[0].win = CW'(8);   tbl[0].nb = 8;   tbl[0].pat = '1;
    tbl[0].res = {16'h0008, 16'h0008, 16'h0008, 16'h0008};
    tbl[1].win = CW'(4);   tbl[1].nb = 4;   tbl[1].pat = '0;
    tbl[1].pat[0] = 4'b0101; tbl[1].pat[1] = 4'b1100;
    tbl[1].pat[2] = 4'b0101; tbl[1].pat[3] = 4'b1101;
    tbl[1].res = {16'h0000, 16'h0004, 16'hFFFC, 16'h0002};
    tbl[2].win = CW'(0);   tbl[2].nb = 1;   tbl[2].pat = '0;
    tbl[2].pat[0] = 4'b1010;
    tbl[2].res = {16'h0001, 16'hFFFF, 16'h0001, 16'hFFFF};
    tbl[3].win = CW'(1);   tbl[3].nb = 1;   tbl[3].pat = '0;
    tbl[3].res = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    tbl[4].win = CW'(3);   tbl[4].nb = 3;   tbl[4].pat = '0;
    tbl[4].pat[0] = 4'b0011; tbl[4].pat[1] = 4'b0011; tbl[4].pat[2] = 4'b1001;
    tbl[4].res = {16'hFFFF, 16'hFFFD, 16'h0001, 16'h0003};
    tbl[5].win = CW'(511); tbl[5].nb = 480; tbl[5].pat = '1;
    tbl[5].res = {16'h01E0, 16'h01E0, 16'h01E0, 16'h01E0};

    bus.clear_i = 1'b0;  bus.win_len_i = CW'(8);  bus.qcorr_valid_i = 1'b0;
    bus.qcorr_data_i = '0;  bus.acc_qcorr_ready_i = 1'b1;
    nbus.clear_i = 1'b0; nbus.win_len_i = CW'(12); nbus.qcorr_valid_i = 1'b0;
    nbus.qcorr_data_i = '1; nbus.acc_qcorr_ready_i = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", bus.acc_qcorr_valid_o, 0);
    chk("reset_data",  bus.acc_qcorr_data_o, 0);
    chk("reset_ready", bus.qcorr_ready_o, 0);
    chk("reset_busy",  bus.acc_busy_o, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      bus.win_len_i = tbl[i].win;
      pulse_clear();
      for (int b = 0; b < tbl[i].nb; b++) send_beat(tbl[i].pat[b % 16]);
      chk("tbl_latency_valid", bus.acc_qcorr_valid_o, 1);
      chk("tbl_ready_low",     bus.qcorr_ready_o, 0);
      chk("tbl_data",          bus.acc_qcorr_data_o, tbl[i].res);
`ifdef ACC_QCORR_SAT_EN
      chk("tbl_sat_flags",     bus.acc_sat_o, 0);
`endif
      tick();
      chk("tbl_valid_drop",    bus.acc_qcorr_valid_o, 0);
      chk("tbl_ready_back",    bus.qcorr_ready_o, 1);
    end

    // Downstream stall: result held, offered beats refused.
    bus.win_len_i = CW'(4);
    pulse_clear();
    bus.acc_qcorr_ready_i = 1'b0;
    for (int b = 0; b < 4; b++) send_beat(tbl[1].pat[b]);
    bus.qcorr_valid_i = 1'b1;
    bus.qcorr_data_i  = 4'hF;
    for (int k = 0; k < 5; k++) begin
      chk("hold_valid", bus.acc_qcorr_valid_o, 1);
      chk("hold_data",  bus.acc_qcorr_data_o, tbl[1].res);
      chk("hold_ready", bus.qcorr_ready_o, 0);
      tick();
    end
    bus.qcorr_valid_i = 1'b0;
    bus.acc_qcorr_ready_i = 1'b1;
    tick();
    chk("hold_release", bus.acc_qcorr_valid_o, 0);

    // Long window with random gaps, then a back-to-back short window.
    bus.win_len_i = CW'(480);
    pulse_clear();
    n0 = n_res;
    for (int i = 0; i < 480; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      send_beat(NC'($urandom));
      if (i == 5) bus.win_len_i = CW'(3);
    end
    chk("rand_valid",      bus.acc_qcorr_valid_o, 1);
    chk("rand_ready_low",  bus.qcorr_ready_o, 0);
    tick();
    chk("rand_b2b_ready",  bus.qcorr_ready_o, 1);
    for (int i = 0; i < 3; i++) send_beat(NC'($urandom));
    chk("rand_b2b_valid",  bus.acc_qcorr_valid_o, 1);
    tick();
    chk("rand_results",    n_res - n0, 2);

    // Clear mid-window and in OUTPUT.
    bus.win_len_i = CW'(10);
    pulse_clear();
    for (int i = 0; i < 5; i++) send_beat(NC'($urandom));
    chk("clr_busy_mid", bus.acc_busy_o, 1);
    bus.clear_i = 1'b1;
    bus.qcorr_valid_i = 1'b1;
    bus.qcorr_data_i  = 4'hF;
    @(negedge clk);
    chk("clr_ready_forced", bus.qcorr_ready_o, 0);
    tick();
    bus.clear_i = 1'b0;
    bus.qcorr_valid_i = 1'b0;
    chk("clr_busy_after", bus.acc_busy_o, 0);
    for (int i = 0; i < 10; i++) send_beat(4'hF);
    chk("clr_fresh_data", bus.acc_qcorr_data_o, 64'h000A000A000A000A);
    tick();
    bus.acc_qcorr_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) send_beat(4'h0);
    chk("clr_out_valid", bus.acc_qcorr_valid_o, 1);
    pulse_clear();
    chk("clr_out_drop", bus.acc_qcorr_valid_o, 0);
    bus.acc_qcorr_ready_i = 1'b1;
    n0 = n_res;
    for (int i = 0; i < 10; i++) send_beat(4'b0101);
    chk("clr_next_data", bus.acc_qcorr_data_o, 64'hFFF6000AFFF6000A);
    tick();
    chk("clr_result_count", n_res - n0, 1);

    // Asynchronous reset mid-window.
    bus.win_len_i = CW'(6);
    pulse_clear();
    for (int i = 0; i < 3; i++) send_beat(4'hF);
    chk("arst_busy_before", bus.acc_busy_o, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.acc_qcorr_valid_o, 0);
    chk("arst_data",  bus.acc_qcorr_data_o, 0);
    chk("arst_ready", bus.qcorr_ready_o, 0);
    chk("arst_busy",  bus.acc_busy_o, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Narrow accumulator driven past its positive range.
    ncnt = 0;
    nbus.qcorr_valid_i = 1'b1;
    for (int k = 0; k < 40 && ncnt < 12; k++) begin
      @(negedge clk);
      if (nbus.qcorr_ready_o) ncnt++;
      tick();
    end
    nbus.qcorr_valid_i = 1'b0;
    chk("narrow_beats", ncnt, 12);
    chk("narrow_valid", nbus.acc_qcorr_valid_o, 1);
`ifdef ACC_QCORR_SAT_EN
    chk("narrow_data_sat", nbus.acc_qcorr_data_o, 16'h7777);
    chk("narrow_sat_flag", nbus.acc_sat_o, 4'hF);
`else
    chk("narrow_data_wrap", nbus.acc_qcorr_data_o, 16'hCCCC);
`endif
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
